// File: rtl/clkdiv_pkg.sv
// Purpose: shared state encoding and constants for the clock divider controller.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package clkdiv_pkg;

    // Default width of the divide counter and of the configuration word.
    localparam int DEF_CNT_W = 16;

    // Smallest usable divide count; 0 and 1 both mean "tick every cycle".
    localparam int MIN_DIV = 1;

    // Controller states: PEND is RUN with a new divide count waiting for
    // the current period to finish.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

endpackage

// File: rtl/clock_divide_core.sv
// Purpose: divide counter, terminal-count compare and clk_div toggle, driven by the FSM.
// Latency: tick is decoded from registers in the cycle cnt==div_r-1; clk_div flips on the following edge.
// Backpressure: none; en/clr/load are obeyed every cycle (clr beats load's counter effects).
module clock_divide_core
    import clkdiv_pkg::*;
#(
    parameter int DIVCOUNT = 25,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick,
    output logic             clk_div
);

    localparam logic [CNT_W-1:0] MIN_VAL = CNT_W'(MIN_DIV);
    localparam logic [CNT_W-1:0] RST_DIV = (DIVCOUNT < MIN_DIV) ? MIN_VAL : CNT_W'(DIVCOUNT);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_r;
    logic             clk_div_r;

    // Terminal count: only meaningful while the FSM says we are running.
    assign tick    = en && (cnt == (div_r - MIN_VAL));
    assign clk_div = clk_div_r;

    // Counter and square-wave register: wrap on terminal count, clear on abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            clk_div_r <= 1'b0;
        end else if (clr) begin
            cnt       <= '0;
            clk_div_r <= 1'b0;
        end else if (en) begin
            if (tick) begin
                cnt       <= '0;
                clk_div_r <= ~clk_div_r;
            end else begin
                cnt <= cnt + MIN_VAL;
            end
        end
    end

    // Divide-count register: loads are clamped so a count of 0 behaves like 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r <= RST_DIV;
        end else if (load) begin
            div_r <= (load_val < MIN_VAL) ? MIN_VAL : load_val;
        end
    end

endmodule

// File: rtl/clock_divide_ctrl.sv
// Purpose: run/stop/reconfigure FSM around a programmable clock divider; optional burst mode under CLOCK_DIVIDE_BURST_EN.
// Latency: first tick div_r cycles after start is sampled; a new count offered while running takes effect after the current period.
// Backpressure: cfg_ready drops while a reload is pending and returns once the pending count is applied.
module clock_divide_ctrl
    import clkdiv_pkg::*;
#(
    parameter int DIVCOUNT = 25,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
`ifdef CLOCK_DIVIDE_BURST_EN
    input  logic [CNT_W-1:0] burst_len,
`endif
    output logic             cfg_ready,
    output logic             tick,
    output logic             clk_div,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [CNT_W-1:0] pend_r;
    logic             xfer;
    logic             last_tick;
    logic             end_run;
    logic             core_clr;
    logic             core_load;
    logic [CNT_W-1:0] core_val;

    assign cfg_ready = (state != PEND);
    assign xfer      = cfg_valid && cfg_ready;

`ifdef CLOCK_DIVIDE_BURST_EN
    logic [CNT_W-1:0] burst_r;
    logic [CNT_W-1:0] tick_cnt;
    logic             done_r;

    // A nonzero burst ends on the tick whose index reaches burst_len.
    assign last_tick = tick && (burst_r != '0) && (tick_cnt == (burst_r - CNT_W'(1)));
    assign done      = done_r;

    // Burst bookkeeping: latch the length at start, count ticks, pulse done after the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_r  <= '0;
            tick_cnt <= '0;
            done_r   <= 1'b0;
        end else begin
            done_r <= last_tick && !stop;
            if (state == IDLE) begin
                tick_cnt <= '0;
                if (start) begin
                    burst_r <= burst_len;
                end
            end else if (tick) begin
                tick_cnt <= tick_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign last_tick = 1'b0;
    assign done      = 1'b0;
`endif

    // Core controls: stop or burst end clears the counter; loads come from cfg in IDLE or from pend_r at a PEND wrap.
    always_comb begin
        end_run   = (busy && stop) || last_tick;
        core_clr  = end_run;
        core_load = 1'b0;
        core_val  = cfg_div;
        case (state)
            IDLE: core_load = xfer;
            PEND: begin
                core_load = tick && !stop;
                core_val  = pend_r;
            end
            RUN:     core_load = xfer && last_tick && !stop;
            default: core_load = 1'b0;
        endcase
    end

    // Control FSM: stop beats start and beats a pending reload on the terminal-count cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            pend_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (end_run) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        pend_r <= '0;
                    end else if (xfer) begin
                        state  <= PEND;
                        pend_r <= cfg_div;
                    end
                end
                PEND: begin
                    if (end_run) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        pend_r <= '0;
                    end else if (tick) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    clock_divide_core #(
        .DIVCOUNT (DIVCOUNT),
        .CNT_W    (CNT_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .en       (busy),
        .clr      (core_clr),
        .load     (core_load),
        .load_val (core_val),
        .tick     (tick),
        .clk_div  (clk_div)
    );

endmodule

// File: tb/tb_clock_divide_ctrl.sv
// Purpose: directed self-checking bench for clock_divide_ctrl (burst case only when CLOCK_DIVIDE_BURST_EN is defined).
// Latency: inputs change 1 time unit after a rising edge and outputs are sampled at that same point.
// Backpressure: cfg_ready is checked around a reload that is pending while running.
module tb_clock_divide_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        cfg_valid;
    logic [15:0] cfg_div;
    logic        cfg_ready;
    logic        tick;
    logic        clk_div;
    logic        busy;
    logic        done;
`ifdef CLOCK_DIVIDE_BURST_EN
    logic [15:0] burst_len;
`endif

    int checks = 0;
    int errors = 0;
    int n;

    clock_divide_ctrl #(
        .DIVCOUNT (25),
        .CNT_W    (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
`ifdef CLOCK_DIVIDE_BURST_EN
        .burst_len (burst_len),
`endif
        .cfg_ready (cfg_ready),
        .tick      (tick),
        .clk_div   (clk_div),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until tick is seen (at least one step); n hits max if it never comes.
    task automatic wait_tick(input int max, output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!tick && cnt < max);
    endtask

    // Pulses start for one cycle and counts cycles up to and including the first tick.
    task automatic start_wait(output int cnt);
        start = 1'b1;
        cnt   = 0;
        do begin
            step();
            cnt++;
            start = 1'b0;
        end while (!tick && cnt < 100);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
`ifdef CLOCK_DIVIDE_BURST_EN
        burst_len = '0;
`endif
        // Reset state
        step(); step(); step();
        chk("rst_tick", tick, 0);
        chk("rst_clk_div", clk_div, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        rst = 1'b0;
        step();

        // Default divide of 25: first tick 25 cycles after start, then every 25
        start_wait(n);
        chk("first_tick_25", n, 25);
        chk("busy_run", busy, 1);
        chk("clk_div_t1", clk_div, 0);
        wait_tick(100, n);
        chk("tick_int_25a", n, 25);
        chk("clk_div_t2", clk_div, 1);
        wait_tick(100, n);
        chk("tick_int_25b", n, 25);
        chk("clk_div_t3", clk_div, 0);

        // Reconfigure to 4 while running: pending until the 25-cycle period ends
        step();
        cfg_valid = 1'b1;
        cfg_div   = 16'd4;
        chk("cfg_ready_run", cfg_ready, 1);
        step();
        cfg_valid = 1'b0;
        chk("cfg_ready_pend", cfg_ready, 0);
        wait_tick(100, n);
        chk("old_period_finish", n, 23);
        chk("cfg_ready_at_wrap", cfg_ready, 0);
        chk("clk_div_t4", clk_div, 1);
        step();
        chk("cfg_ready_back", cfg_ready, 1);
        wait_tick(100, n);
        chk("tick_int_4a", n, 3);
        wait_tick(100, n);
        chk("tick_int_4b", n, 4);
        chk("clk_div_t6", clk_div, 1);

        // start and stop together on a terminal-count cycle: stop wins
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_clk_div", clk_div, 0);
        chk("stop_tick", tick, 0);
        chk("stop_done", done, 0);
        step(); step();
        chk("stop_stays_idle", busy, 0);

        // cfg_div=0 clamps to 1: tick every cycle, clk_div toggles every cycle
        cfg_valid = 1'b1;
        cfg_div   = 16'd0;
        step();
        cfg_valid = 1'b0;
        start_wait(n);
        chk("div1_first_tick", n, 1);
        chk("div1_clk_div_a", clk_div, 0);
        step();
        chk("div1_tick_b", tick, 1);
        chk("div1_clk_div_b", clk_div, 1);
        step();
        chk("div1_tick_c", tick, 1);
        chk("div1_clk_div_c", clk_div, 0);

        // Reset mid-period restores defaults and ignores inputs while held
        stop = 1'b1;
        step();
        stop      = 1'b0;
        cfg_valid = 1'b1;
        cfg_div   = 16'd7;
        step();
        cfg_valid = 1'b0;
        start_wait(n);
        chk("div7_first_tick", n, 7);
        step(); step();
        chk("pre_rst_clk_div", clk_div, 1);
        rst       = 1'b1;
        start     = 1'b1;
        cfg_valid = 1'b1;
        cfg_div   = 16'd9;
        step();
        chk("mid_rst_tick", tick, 0);
        chk("mid_rst_clk_div", clk_div, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cfg_ready", cfg_ready, 1);
        step();
        chk("rst_ignores_start", busy, 0);
        rst       = 1'b0;
        start     = 1'b0;
        cfg_valid = 1'b0;
        start_wait(n);
        chk("div_back_to_25", n, 25);

        // Stop while a reload is pending discards it
        step();
        cfg_valid = 1'b1;
        cfg_div   = 16'd4;
        step();
        cfg_valid = 1'b0;
        chk("pend_before_stop", cfg_ready, 0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("pend_stop_busy", busy, 0);
        chk("pend_stop_ready", cfg_ready, 1);
        start_wait(n);
        chk("pend_discarded", n, 25);

`ifdef CLOCK_DIVIDE_BURST_EN
        // Burst of 3 ticks at divide 5
        stop = 1'b1;
        step();
        stop      = 1'b0;
        cfg_valid = 1'b1;
        cfg_div   = 16'd5;
        step();
        cfg_valid = 1'b0;
        burst_len = 16'd3;
        start_wait(n);
        burst_len = 16'd0;
        chk("burst_t1", n, 5);
        wait_tick(100, n);
        chk("burst_t2", n, 5);
        wait_tick(100, n);
        chk("burst_t3", n, 5);
        chk("burst_t3_done", done, 0);
        chk("burst_t3_busy", busy, 1);
        step();
        chk("burst_done", done, 1);
        chk("burst_idle", busy, 0);
        chk("burst_end_tick", tick, 0);
        chk("burst_end_clk_div", clk_div, 0);
        step();
        chk("burst_done_pulse", done, 0);
        wait_tick(20, n);
        chk("burst_no_more_ticks", n, 20);
        chk("burst_quiet_tick", tick, 0);
`else
        chk("done_tied_low", done, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_divide_ctrl.md
CLOCK_DIVIDE_CTRL -- requirements
Module: clock_divide_ctrl

Interface
REQ-001 SHALL have parameter DIVCOUNT, default 25, meaning the divide count loaded at reset (clk cycles per tick).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the divide counter and of cfg_div.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle run request.
REQ-006 SHALL have port stop, input, 1 bit: single-cycle halt request.
REQ-007 SHALL have port cfg_valid, input, 1 bit: a new divide count is offered.
REQ-008 SHALL have port cfg_div, input, CNT_W bits: the offered divide count.
REQ-009 SHALL have port cfg_ready, output, 1 bit: the block can accept a configuration.
REQ-010 SHALL have port tick, output, 1 bit: single-cycle enable strobe, asserted on each terminal count.
REQ-011 SHALL have port clk_div, output, 1 bit: registered square wave that toggles on each tick.
REQ-012 SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-013 SHALL have port done, output, 1 bit: single-cycle burst-complete pulse (see Configuration).

Function
REQ-014 SHALL implement states IDLE, RUN and PEND (RUN with a configuration pending).
REQ-015 SHALL, in RUN/PEND, count cnt from 0 to div_r-1 and wrap to 0; tick=1 for exactly the cycle cnt==div_r-1; clk_div period = 2*div_r cycles.
REQ-016 SHALL clamp the divide count: cfg_div of 0 or 1 stores div_r=1, so tick is high every cycle.
REQ-017 SHALL drive cfg_ready=1 in IDLE and RUN and cfg_ready=0 in PEND; a transfer occurs when cfg_valid&&cfg_ready.
REQ-018 SHALL, on a transfer in IDLE, load div_r on the next edge.
REQ-019 SHALL, on a transfer in RUN, store the value in pend_r and go to PEND; at the next terminal count (tick still issued with the old count) load div_r=pend_r, clear cnt and return to RUN; no period is truncated.
REQ-020 SHALL, on start in IDLE, go to RUN with cnt=0, so the first tick occurs div_r cycles after start is sampled.
REQ-021 SHALL ignore start outside IDLE.
REQ-022 SHALL, on stop in RUN/PEND, go to IDLE on the next edge: cnt=0, clk_div=0, tick=0 that cycle, and any pending configuration discarded.
REQ-023 SHALL give stop priority over start when both are high in the same cycle, and give stop priority over a pending reload on a terminal-count cycle.

Reset
REQ-024 SHALL, while rst=1, set state=IDLE, cnt=0, div_r=DIVCOUNT (clamped), pend_r=0, tick=0, clk_div=0, busy=0 and done=0.
REQ-025 SHALL, while rst=1, ignore cfg_valid, start and stop; rst asserted mid-run aborts the run with no further tick.

Configuration
REQ-026 SHALL provide macro CLOCK_DIVIDE_BURST_EN: when defined, add input burst_len[CNT_W-1:0], sampled at start; a nonzero value ends the run after exactly burst_len ticks by going to IDLE and pulsing done in the cycle after the last tick; zero means free-running.
REQ-027 SHALL, without CLOCK_DIVIDE_BURST_EN, omit burst_len, tie done to 0 and run until stop.

Structure
REQ-028 SHALL place the state encoding (IDLE/RUN/PEND), the CNT_W default and the minimum divide constant (1) in a shared package, clkdiv_pkg.
REQ-029 SHALL use one sub-module, clock_divide_core, holding the counter, the terminal-count compare and the clk_div toggle, with its enable, clear and load driven by the FSM.

Verification
REQ-030 SHALL verify: reset, then start with DIVCOUNT=25 -> first tick 25 cycles after start, then a tick every 25 cycles, clk_div period 50.
REQ-031 SHALL verify: a cfg_div=4 transfer in RUN -> cfg_ready low until the current 25-cycle period ends, then a tick every 4 cycles.
REQ-032 SHALL verify: cfg_div=0 loaded in IDLE, then start -> tick high every cycle, clk_div toggling every cycle.
REQ-033 SHALL verify: start and stop high in the same cycle of RUN -> IDLE next cycle, busy=0, clk_div=0, no tick.
REQ-034 SHALL verify: rst pulse mid-period -> all outputs at reset values the next cycle and div_r back to 25.
REQ-035 SHALL verify, with CLOCK_DIVIDE_BURST_EN: burst_len=3, div 5 -> exactly 3 ticks, done one cycle after the third tick, then IDLE.
